apb_stream_uart_fifo: RTL and testbench

Parametrised successor to the single-stream APB UART that bridges the CDC byte streams to the target UART.
- Adds TX/RX FIFOs of configurable depth, a runtime baud divisor, parity and stop-bit modes, and per-direction source selection (stream or APB register).
- Adds sticky error flags and an interrupt line.
- Sits on an APB port of the Cortex-M1; the stream side connects to the USB CDC endpoints.

---
 rtl/apb_stream_uart_fifo.sv | 341 ++++++++++++++++++++++++++++++++++
 tb/tb_apb_stream_uart_fifo.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_stream_uart_fifo.sv
// APB UART with TX/RX byte FIFOs bridging byte streams to a serial line.
// Optional internal TX->RX loopback (CTRL.LOOP) when UART_LOOPBACK_EN is defined.

module apb_stream_uart_fifo_buf #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [W-1:0]            wdata,
    input  logic                    pop,
    output logic [W-1:0]            rdata,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr, rptr;
    logic         do_push, do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign count   = wptr - rptr;
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end
endmodule

module apb_stream_uart_fifo #(
    parameter int                   FIFO_DEPTH  = 16,
    parameter int                   DIV_WIDTH   = 16,
    parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV = 16'd433
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [11:0] PADDR,
    input  logic [31:0] PWDATA,
    input  logic [3:0]  PSTRB,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic        tx_tvalid,
    output logic        tx_tready,
    input  logic [7:0]  tx_tdata,
    output logic        rx_tvalid,
    input  logic        rx_tready,
    output logic [7:0]  rx_tdata,
    output logic        UART_TX,
    input  logic        UART_RX,
    output logic        intr
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [11:0] A_CTRL = 12'h000, A_BAUD = 12'h004, A_STAT = 12'h008,
                            A_DATA = 12'h00C, A_LEVEL = 12'h010;
`ifdef UART_LOOPBACK_EN
    localparam logic [10:0] CTRL_MASK = 11'h77F;
`else
    localparam logic [10:0] CTRL_MASK = 11'h73F;
`endif

    typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP1, T_STOP2} tx_state_t;
    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP} rx_state_t;

    logic [10:0]          ctrl_q;
    logic [DIV_WIDTH-1:0] div;
    logic                 perr, ferr, ovr;
    logic                 en, tx_src, rx_dst, par_en, par_odd, stop2;

    assign en      = ctrl_q[0];
    assign tx_src  = ctrl_q[1];
    assign rx_dst  = ctrl_q[2];
    assign par_en  = ^ctrl_q[4:3];
    assign par_odd = ctrl_q[4];
    assign stop2   = ctrl_q[5];

    // FIFOs
    logic          tx_push, tx_pop, tx_full, tx_empty;
    logic          rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]    tx_wdata, tx_head, rx_head, rx_sh;
    logic [CW-1:0] tx_cnt, rx_cnt;

    apb_stream_uart_fifo_buf #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
        .clk(PCLK), .rst(PRESET), .push(tx_push), .wdata(tx_wdata), .pop(tx_pop),
        .rdata(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_cnt));

    apb_stream_uart_fifo_buf #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
        .clk(PCLK), .rst(PRESET), .push(rx_push), .wdata(rx_sh), .pop(rx_pop),
        .rdata(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_cnt));

    // APB decode
    logic        access, apb_wr, data_push_apb, data_pop_apb, stat_wr;
    logic [31:0] prdata_c;
    logic        slverr_c;
    logic        tx_busy;

    assign access        = PSEL & PENABLE;
    assign apb_wr        = access & PWRITE;
    assign stat_wr       = apb_wr && (PADDR == A_STAT);
    assign data_push_apb = apb_wr && (PADDR == A_DATA) && PSTRB[0] && tx_src && !tx_full;
    assign data_pop_apb  = access && !PWRITE && (PADDR == A_DATA) && rx_dst && !rx_empty;

    always_comb begin
        prdata_c = '0;
        slverr_c = 1'b0;
        if (access) begin
            case (PADDR)
                A_CTRL:  prdata_c = {21'd0, ctrl_q};
                A_BAUD:  prdata_c = 32'(div);
                A_STAT:  prdata_c = {21'd0, ovr, ferr, perr, 3'd0,
                                     tx_busy, rx_empty, rx_full, tx_empty, tx_full};
                A_DATA: begin
                    if (PWRITE)                  slverr_c = tx_full | ~tx_src;
                    else if (rx_empty | ~rx_dst) slverr_c = 1'b1;
                    else                         prdata_c = {24'd0, rx_head};
                end
                A_LEVEL: prdata_c = {16'(rx_cnt), 16'(tx_cnt)};
                default: slverr_c = 1'b1;
            endcase
            if (PWRITE) prdata_c = '0;
        end
    end

    assign PRDATA  = prdata_c;
    assign PSLVERR = slverr_c;
    assign PREADY  = 1'b1;

    // Stream side
    assign tx_tready = en & ~tx_src & ~tx_full;
    assign tx_push   = tx_src ? data_push_apb : (tx_tvalid & tx_tready);
    assign tx_wdata  = tx_src ? PWDATA[7:0] : tx_tdata;
    assign rx_tvalid = ~rx_dst & ~rx_empty;
    assign rx_tdata  = rx_tvalid ? rx_head : 8'd0;
    assign rx_pop    = rx_dst ? data_pop_apb : (rx_tvalid & rx_tready);

    // Transmitter
    tx_state_t            tx_state, tx_state_n;
    logic [DIV_WIDTH-1:0] tx_bcnt, tx_bcnt_n;
    logic [7:0]           tx_sh, tx_sh_n;
    logic [2:0]           tx_bit, tx_bit_n;
    logic                 tx_par, tx_par_n, tx_line, txd_q, tx_go, tx_tick;

    assign tx_go   = en & ~tx_empty;
    assign tx_tick = (tx_bcnt >= div);
    assign tx_busy = (tx_state != T_IDLE);

    always_comb begin
        tx_state_n = tx_state;
        tx_bcnt_n  = tx_tick ? '0 : tx_bcnt + 1'b1;
        tx_sh_n    = tx_sh;
        tx_bit_n   = tx_bit;
        tx_par_n   = tx_par;
        tx_pop     = 1'b0;
        tx_line    = 1'b1;
        case (tx_state)
            T_IDLE: tx_bcnt_n = '0;
            T_START: begin
                tx_line = 1'b0;
                if (tx_tick) begin
                    tx_state_n = T_DATA;
                    tx_bit_n   = '0;
                end
            end
            T_DATA: begin
                tx_line = tx_sh[0];
                if (tx_tick) begin
                    tx_sh_n  = tx_sh >> 1;
                    tx_bit_n = tx_bit + 1'b1;
                    if (tx_bit == 3'd7) tx_state_n = par_en ? T_PAR : T_STOP1;
                end
            end
            T_PAR: begin
                tx_line = tx_par;
                if (tx_tick) tx_state_n = T_STOP1;
            end
            T_STOP1: if (tx_tick) tx_state_n = stop2 ? T_STOP2 : T_IDLE;
            T_STOP2: if (tx_tick) tx_state_n = T_IDLE;
            default: tx_state_n = T_IDLE;
        endcase
        // Next frame loads straight out of the last stop bit, no idle gap.
        if (tx_go && (tx_state == T_IDLE || tx_state_n == T_IDLE && tx_tick)) begin
            tx_pop     = 1'b1;
            tx_sh_n    = tx_head;
            tx_par_n   = ^tx_head ^ par_odd;
            tx_state_n = T_START;
            tx_bcnt_n  = '0;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            tx_state <= T_IDLE;
            tx_bcnt  <= '0;
            tx_sh    <= '0;
            tx_bit   <= '0;
            tx_par   <= 1'b0;
            txd_q    <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_bcnt  <= tx_bcnt_n;
            tx_sh    <= tx_sh_n;
            tx_bit   <= tx_bit_n;
            tx_par   <= tx_par_n;
            txd_q    <= tx_line;
        end
    end

    // Receiver
    rx_state_t            rx_state, rx_state_n;
    logic [DIV_WIDTH-1:0] rx_bcnt, rx_bcnt_n;
    logic [7:0]           rx_sh_n;
    logic [2:0]           rx_bit, rx_bit_n;
    logic                 rx_pe, rx_pe_n, rx_s1, rx_s2, rxd, rxd_prev, rx_tick;
    logic                 perr_set, ferr_set, ovr_set;

`ifdef UART_LOOPBACK_EN
    assign rxd     = ctrl_q[6] ? txd_q : rx_s2;
    assign UART_TX = ctrl_q[6] ? 1'b1 : txd_q;
`else
    assign rxd     = rx_s2;
    assign UART_TX = txd_q;
`endif

    assign rx_tick = (rx_bcnt >= div);
    assign ovr_set = rx_push & rx_full & ~rx_pop;

    always_comb begin
        rx_state_n = rx_state;
        rx_bcnt_n  = rx_bcnt + 1'b1;
        rx_sh_n    = rx_sh;
        rx_bit_n   = rx_bit;
        rx_pe_n    = rx_pe;
        rx_push    = 1'b0;
        perr_set   = 1'b0;
        ferr_set   = 1'b0;
        case (rx_state)
            R_IDLE: begin
                rx_bcnt_n = '0;
                if (rxd_prev && !rxd) rx_state_n = R_START;
            end
            R_START: if (rx_bcnt >= (div >> 1)) begin
                rx_bcnt_n  = '0;
                rx_state_n = rxd ? R_IDLE : R_DATA;
                rx_bit_n   = '0;
                rx_pe_n    = 1'b0;
            end
            R_DATA: if (rx_tick) begin
                rx_bcnt_n = '0;
                rx_sh_n   = {rxd, rx_sh[7:1]};
                rx_bit_n  = rx_bit + 1'b1;
                if (rx_bit == 3'd7) rx_state_n = par_en ? R_PAR : R_STOP;
            end
            R_PAR: if (rx_tick) begin
                rx_bcnt_n  = '0;
                rx_pe_n    = rxd ^ (^rx_sh) ^ par_odd;
                rx_state_n = R_STOP;
            end
            R_STOP: if (rx_tick) begin
                rx_state_n = R_IDLE;
                if (!rxd)       ferr_set = 1'b1;
                else if (rx_pe) perr_set = 1'b1;
                else            rx_push  = 1'b1;
            end
            default: rx_state_n = R_IDLE;
        endcase
        if (!en) begin
            rx_state_n = R_IDLE;
            rx_bcnt_n  = '0;
            rx_push    = 1'b0;
            perr_set   = 1'b0;
            ferr_set   = 1'b0;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            rx_state <= R_IDLE;
            rx_bcnt  <= '0;
            rx_sh    <= '0;
            rx_bit   <= '0;
            rx_pe    <= 1'b0;
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rx_state <= rx_state_n;
            rx_bcnt  <= rx_bcnt_n;
            rx_sh    <= rx_sh_n;
            rx_bit   <= rx_bit_n;
            rx_pe    <= rx_pe_n;
            rx_s1    <= UART_RX;
            rx_s2    <= rx_s1;
            rxd_prev <= rxd;
        end
    end

    // Control/status registers; a new error wins over a same-cycle W1C.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            ctrl_q <= '0;
            div    <= DEFAULT_DIV;
            perr   <= 1'b0;
            ferr   <= 1'b0;
            ovr    <= 1'b0;
            intr   <= 1'b0;
        end else begin
            if (apb_wr && PADDR == A_CTRL) ctrl_q <= PWDATA[10:0] & CTRL_MASK;
            if (apb_wr && PADDR == A_BAUD)
                div <= (PWDATA[DIV_WIDTH-1:0] < DIV_WIDTH'(3)) ? DIV_WIDTH'(3)
                                                                : PWDATA[DIV_WIDTH-1:0];
            perr <= perr_set | (perr & ~(stat_wr & PWDATA[8]));
            ferr <= ferr_set | (ferr & ~(stat_wr & PWDATA[9]));
            ovr  <= ovr_set  | (ovr  & ~(stat_wr & PWDATA[10]));
            intr <= (ctrl_q[8] & ~rx_empty) | (ctrl_q[9] & tx_empty) |
                    (ctrl_q[10] & (perr | ferr | ovr));
        end
    end

    logic unused_inputs;
    assign unused_inputs = ^{PWDATA[31:DIV_WIDTH], PSTRB[3:1]};
endmodule

// File: tb/tb_apb_stream_uart_fifo.sv
// Directed bench for apb_stream_uart_fifo: register table, TX framing, RX parity/stop
// errors, RX overflow with a 4-deep FIFO, and loopback when UART_LOOPBACK_EN is defined.

module tb_apb_stream_uart_fifo;
    logic        PCLK = 1'b0;
    logic        PRESET, PSEL, PENABLE, PWRITE;
    logic [11:0] PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic [3:0]  PSTRB;
    logic        PREADY, PSLVERR;
    logic        tx_tvalid, tx_tready, rx_tvalid, rx_tready;
    logic [7:0]  tx_tdata, rx_tdata;
    logic        UART_TX, UART_RX, intr;

    int n_chk  = 0;
    int n_fail = 0;

    apb_stream_uart_fifo #(.FIFO_DEPTH(4)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tdata(tx_tdata),
        .rx_tvalid(rx_tvalid), .rx_tready(rx_tready), .rx_tdata(rx_tdata),
        .UART_TX(UART_TX), .UART_RX(UART_RX), .intr(intr));

    always #5 PCLK = ~PCLK;

`ifdef UART_LOOPBACK_EN
    localparam logic [31:0] CTRL_ALL = 32'h77F;
`else
    localparam logic [31:0] CTRL_ALL = 32'h73F;
`endif

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } apb_vec_t;

    localparam int NV = 20;
    apb_vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apb_xfer(input logic w, input logic [11:0] a, input logic [31:0] d,
                            output logic [31:0] r, output logic e);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d; PSTRB = 4'hF;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1;
        r = PRDATA;
        e = PSLVERR;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_chk(input string name, input logic w, input logic [11:0] a,
                           input logic [31:0] d, input logic [31:0] exp_r, input logic exp_e);
        logic [31:0] r;
        logic        e;
        apb_xfer(w, a, d, r, e);
        if (!w) check({name, " rdata"}, r, exp_r);
        check({name, " pslverr"}, {31'd0, e}, {31'd0, exp_e});
    endtask

    task automatic drive_bit(input logic b);
        UART_RX = b;
        repeat (4) @(negedge PCLK);
    endtask

    // Serial frame at 4 cycles/bit (BAUD=3), optional parity bit.
    task automatic send_byte(input logic [7:0] d, input logic par_on, input logic par_bit,
                             input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (par_on) drive_bit(par_bit);
        drive_bit(stop_bit);
        UART_RX = 1'b1;
        repeat (8) @(negedge PCLK);
    endtask

    function automatic logic [9:0] frame(input logic [7:0] d);
        return {1'b1, d, 1'b0};
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [19:0] exp_bits;
        logic [3:0]  samp;
        logic [7:0]  ovr_bytes [5];
        int          t, lows;

        vecs[0]  = '{1'b0, 12'h000, 32'h0,   32'h0,     1'b0};
        vecs[1]  = '{1'b0, 12'h004, 32'h0,   32'h1B1,   1'b0};
        vecs[2]  = '{1'b0, 12'h008, 32'h0,   32'h0A,    1'b0};
        vecs[3]  = '{1'b0, 12'h00C, 32'h0,   32'h0,     1'b1};
        vecs[4]  = '{1'b0, 12'h010, 32'h0,   32'h0,     1'b0};
        vecs[5]  = '{1'b0, 12'h014, 32'h0,   32'h0,     1'b1};
        vecs[6]  = '{1'b1, 12'h004, 32'h0,   32'h0,     1'b0};
        vecs[7]  = '{1'b0, 12'h004, 32'h0,   32'h3,     1'b0};
        vecs[8]  = '{1'b1, 12'h004, 32'h2,   32'h0,     1'b0};
        vecs[9]  = '{1'b0, 12'h004, 32'h0,   32'h3,     1'b0};
        vecs[10] = '{1'b1, 12'h004, 32'h4,   32'h0,     1'b0};
        vecs[11] = '{1'b0, 12'h004, 32'h0,   32'h4,     1'b0};
        vecs[12] = '{1'b1, 12'h000, 32'h7FF, 32'h0,     1'b0};
        vecs[13] = '{1'b0, 12'h000, 32'h0,   CTRL_ALL,  1'b0};
        vecs[14] = '{1'b1, 12'h000, 32'h001, 32'h0,     1'b0};
        vecs[15] = '{1'b1, 12'h00C, 32'h11,  32'h0,     1'b1};
        vecs[16] = '{1'b0, 12'h008, 32'h0,   32'h0A,    1'b0};
        vecs[17] = '{1'b1, 12'h004, 32'h3,   32'h0,     1'b0};
        vecs[18] = '{1'b0, 12'hFFC, 32'h0,   32'h0,     1'b1};
        vecs[19] = '{1'b0, 12'h000, 32'h0,   32'h1,     1'b0};

        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0;
        PWDATA = '0; PSTRB = '0; tx_tvalid = 1'b0; tx_tdata = '0; rx_tready = 1'b0;
        UART_RX = 1'b1;
        repeat (3) @(negedge PCLK);
        PRESET = 1'b0;
        @(negedge PCLK);

        // Reset state of outputs
        check("reset UART_TX", {31'd0, UART_TX}, 32'd1);
        check("reset intr", {31'd0, intr}, 32'd0);
        check("reset tx_tready", {31'd0, tx_tready}, 32'd0);
        check("reset rx_tvalid", {31'd0, rx_tvalid}, 32'd0);
        check("reset rx_tdata", {24'd0, rx_tdata}, 32'd0);
        check("reset PRDATA", PRDATA, 32'd0);
        check("reset PSLVERR", {31'd0, PSLVERR}, 32'd0);
        check("PREADY", {31'd0, PREADY}, 32'd1);

        // Register table
        for (int i = 0; i < NV; i++)
            apb_chk($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                    vecs[i].exp_rdata, vecs[i].exp_err);

        // TX-empty interrupt
        apb_chk("ctrl txe_ie", 1'b1, 12'h000, 32'h201, 32'h0, 1'b0);
        repeat (2) @(negedge PCLK);
        check("intr txe", {31'd0, intr}, 32'd1);
        apb_chk("ctrl en", 1'b1, 12'h000, 32'h001, 32'h0, 1'b0);
        repeat (2) @(negedge PCLK);
        check("intr off", {31'd0, intr}, 32'd0);

        // Stream TX of 0x55, 0xA3: back-to-back frames, 4 cycles per bit
        tx_tvalid = 1'b1; tx_tdata = 8'h55;
        check("tx_tready 1st", {31'd0, tx_tready}, 32'd1);
        @(negedge PCLK);
        tx_tdata = 8'hA3;
        check("tx_tready 2nd", {31'd0, tx_tready}, 32'd1);
        @(negedge PCLK);
        tx_tvalid = 1'b0;
        t = 0;
        while (UART_TX === 1'b1 && t < 50) begin
            @(negedge PCLK);
            t++;
        end
        check("tx start seen", {31'd0, t < 50}, 32'd1);
        exp_bits = {frame(8'hA3), frame(8'h55)};
        for (int b = 0; b < 20; b++) begin
            for (int s = 0; s < 4; s++) begin
                samp[s] = UART_TX;
                @(negedge PCLK);
            end
            check($sformatf("tx bit%0d", b), {28'd0, samp}, {28'd0, {4{exp_bits[b]}}});
        end
        check("tx idle after", {31'd0, UART_TX}, 32'd1);
        apb_chk("status after tx", 1'b0, 12'h008, 32'h0, 32'h0A, 1'b0);

        // APB RX with even parity
        apb_chk("ctrl 0x0F", 1'b1, 12'h000, 32'h0F, 32'h0, 1'b0);
        send_byte(8'h5A, 1'b1, ^8'h5A, 1'b1);
        apb_chk("status rx", 1'b0, 12'h008, 32'h0, 32'h02, 1'b0);
        apb_chk("level rx", 1'b0, 12'h010, 32'h0, 32'h10000, 1'b0);
        apb_chk("data rd", 1'b0, 12'h00C, 32'h0, 32'h5A, 1'b0);
        apb_chk("data rd empty", 1'b0, 12'h00C, 32'h0, 32'h0, 1'b1);

        // Parity then framing error
        send_byte(8'h5A, 1'b1, ~(^8'h5A), 1'b1);
        send_byte(8'h33, 1'b1, ^8'h33, 1'b0);
        apb_chk("ctrl err_ie", 1'b1, 12'h000, 32'h40F, 32'h0, 1'b0);
        apb_chk("status errs", 1'b0, 12'h008, 32'h0, 32'h30A, 1'b0);
        apb_chk("level errs", 1'b0, 12'h010, 32'h0, 32'h0, 1'b0);
        check("intr err", {31'd0, intr}, 32'd1);
        apb_chk("w1c", 1'b1, 12'h008, 32'h300, 32'h0, 1'b0);
        apb_chk("status cleared", 1'b0, 12'h008, 32'h0, 32'h0A, 1'b0);
        repeat (2) @(negedge PCLK);
        check("intr cleared", {31'd0, intr}, 32'd0);

        // Overflow into a 4-deep stream-side RX FIFO
        ovr_bytes[0] = 8'h11; ovr_bytes[1] = 8'h22; ovr_bytes[2] = 8'h33;
        ovr_bytes[3] = 8'h44; ovr_bytes[4] = 8'h55;
        apb_chk("ctrl 0x0B", 1'b1, 12'h000, 32'h0B, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) send_byte(ovr_bytes[i], 1'b1, ^ovr_bytes[i], 1'b1);
        apb_chk("level ovr", 1'b0, 12'h010, 32'h0, 32'h40000, 1'b0);
        apb_chk("status ovr", 1'b0, 12'h008, 32'h0, 32'h406, 1'b0);
        rx_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rx_tvalid %0d", i), {31'd0, rx_tvalid}, 32'd1);
            check($sformatf("rx_tdata %0d", i), {24'd0, rx_tdata}, {24'd0, ovr_bytes[i]});
            @(negedge PCLK);
        end
        check("rx drained", {31'd0, rx_tvalid}, 32'd0);
        rx_tready = 1'b0;

`ifdef UART_LOOPBACK_EN
        apb_chk("clr errs", 1'b1, 12'h008, 32'h700, 32'h0, 1'b0);
        apb_chk("ctrl loop", 1'b1, 12'h000, 32'h47, 32'h0, 1'b0);
        apb_chk("loop data wr", 1'b1, 12'h00C, 32'hC3, 32'h0, 1'b0);
        lows = 0;
        for (int c = 0; c < 60; c++) begin
            if (UART_TX !== 1'b1) lows++;
            @(negedge PCLK);
        end
        check("loop UART_TX held", lows, 0);
        apb_chk("loop data rd", 1'b0, 12'h00C, 32'h0, 32'hC3, 1'b0);
`else
        lows = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
